// File: rtl/axis_packer_pkg.sv
// rtl/axis_packer_pkg.sv - shared types, widths and helpers for the byte packer
//
// Purpose: common definitions for axis_byte_packer and its output register.
//   out_state_t  : output holding register state (EMPTY/FULL)
//   keep_mask()  : LSB-contiguous byte-valid mask with n low bits set
//   CNT_W, FC_W  : counter widths for the default configuration
// Ports: none (package).
package axis_packer_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Widest word the mask helper covers; callers size-cast to BYTES.
    localparam int MAX_BYTES       = 64;
    localparam int DEF_BYTES       = 4;
    localparam int DEF_FRAME_WORDS = 16;
    localparam int CNT_W           = $clog2(DEF_BYTES);
    localparam int FC_W            = (DEF_FRAME_WORDS > 1) ? $clog2(DEF_FRAME_WORDS) : 1;

    function automatic logic [MAX_BYTES-1:0] keep_mask(input int n);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_packer_out_reg.sv
// rtl/axis_packer_out_reg.sv - single-entry output holding register with valid/ready
//
// Purpose: holds one packed word for the AXI-Stream master side. A load
//   writes data/keep/last and marks the register FULL; a downstream
//   handshake empties it unless a new load arrives on the same edge.
//   Contents stay frozen while tvalid=1 and tready=0.
// Ports:
//   aclk, areset       clock, synchronous active-high reset
//   load               write load_data/keep/last this edge
//   load_data/keep/last word to be stored
//   can_load           register is empty or draining this cycle
//   m_axis_*           AXI-Stream master outputs (tvalid/tready/tdata/tkeep/tlast)
module axis_packer_out_reg
    import axis_packer_pkg::*;
#(
    parameter int BYTES = 4
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               load,
    input  logic [8*BYTES-1:0] load_data,
    input  logic [BYTES-1:0]   load_keep,
    input  logic               load_last,
    output logic               can_load,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [8*BYTES-1:0] m_axis_tdata,
    output logic [BYTES-1:0]   m_axis_tkeep,
    output logic               m_axis_tlast
);

    out_state_t state;
    out_state_t state_next;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (load) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (load) begin
                    state_next = FULL;
                end else if (m_axis_tready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Upstream only issues a load when can_load is high, so a FULL word
    // is never overwritten before it has been accepted.
    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tdata <= '0;
            m_axis_tkeep <= '0;
            m_axis_tlast <= 1'b0;
        end else if (load) begin
            m_axis_tdata <= load_data;
            m_axis_tkeep <= load_keep;
            m_axis_tlast <= load_last;
        end
    end

    assign m_axis_tvalid = (state == FULL);
    assign can_load      = (state == EMPTY) || m_axis_tready;

endmodule

// File: rtl/axis_byte_packer.sv
// rtl/axis_byte_packer.sv - 8-bit to BYTES-wide AXI-Stream packer with framing and flush
//
// Purpose: packs consecutive input bytes little-endian into BYTES-wide words,
//   emits them with tkeep, raises tlast every FRAME_WORDS words, and on a
//   flush pulse emits the current partial word with tlast.
// Ports:
//   aclk, areset   clock, synchronous active-high reset
//   flush          pulse: emit the partial word (held pending if output busy)
//   s_axis_*       8-bit AXI-Stream slave (tvalid/tready/tdata)
//   m_axis_*       BYTES-wide AXI-Stream master (tvalid/tready/tdata/tkeep/tlast)
module axis_byte_packer
    import axis_packer_pkg::*;
#(
    parameter int BYTES       = 4,
    parameter int FRAME_WORDS = 16
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               flush,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [7:0]         s_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [8*BYTES-1:0] m_axis_tdata,
    output logic [BYTES-1:0]   m_axis_tkeep,
    output logic               m_axis_tlast
);

    localparam int DW  = 8 * BYTES;
    localparam int CW  = (BYTES == DEF_BYTES) ? CNT_W : $clog2(BYTES);
    localparam int FWW = (FRAME_WORDS == DEF_FRAME_WORDS) ? FC_W :
                         ((FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(BYTES - 1);
    localparam logic [FWW-1:0] FC_LAST  = FWW'(FRAME_WORDS - 1);

    logic [DW-1:0]  acc;
    logic [CW-1:0]  cnt;
    logic [FWW-1:0] fc;
    logic           flush_pend;

    logic           can_load;
    logic           acc_hs;
    logic [DW-1:0]  word_next;
    logic [CW:0]    n_held;
    logic           has_data;
    logic           flush_req;
    logic           complete;
    logic           flush_load;
    logic           load;
    logic           load_last;
    logic [BYTES-1:0] load_keep;

    // Only the byte that would complete a word has to wait for the output
    // register; earlier lanes keep filling while the output is stalled.
    assign s_axis_tready = !areset && ((cnt != CNT_LAST) || can_load);
    assign acc_hs        = s_axis_tvalid && s_axis_tready;

    // Accumulator including the byte accepted this cycle, so a flush on the
    // same edge carries that byte too.
    always_comb begin
        word_next = acc;
        for (int k = 0; k < BYTES; k++) begin
            if (acc_hs && (cnt == CW'(k))) begin
                word_next[8*k +: 8] = s_axis_tdata;
            end
        end
    end

    assign n_held     = {1'b0, cnt} + {{CW{1'b0}}, acc_hs};
    assign has_data   = (n_held != '0);
    assign flush_req  = flush || flush_pend;
    assign complete   = acc_hs && (cnt == CNT_LAST);
    assign flush_load = flush_req && has_data && can_load;
    assign load       = complete || flush_load;
    assign load_last  = flush_load || (fc == FC_LAST);
    assign load_keep  = BYTES'(keep_mask(int'(n_held)));

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc        <= '0;
            cnt        <= '0;
            fc         <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (load) begin
                acc <= '0;
                cnt <= '0;
                if (flush_load || (fc == FC_LAST)) begin
                    fc <= '0;
                end else begin
                    fc <= fc + 1'b1;
                end
            end else if (acc_hs) begin
                acc <= word_next;
                cnt <= cnt + 1'b1;
            end
            // A flush with nothing held is dropped; one that cannot load yet
            // waits here until the output register frees up.
            flush_pend <= flush_req && has_data && !load;
        end
    end

    axis_packer_out_reg #(
        .BYTES (BYTES)
    ) u_out_reg (
        .aclk          (aclk),
        .areset        (areset),
        .load          (load),
        .load_data     (word_next),
        .load_keep     (load_keep),
        .load_last     (load_last),
        .can_load      (can_load),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

endmodule
